// File: rtl/sie_defs_pkg.sv
// Shared SIE definitions: transmit-arbiter FSM states and index-width helper.
package sie_defs_pkg;

   typedef enum logic [2:0] {
      TX_ARB_IDLE,
      TX_ARB_REQ,
      TX_ARB_STREAM,
      TX_ARB_WAIT_DONE,
      TX_ARB_GAP
   } tx_arb_state_t;

   // Channel index width, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin pick: first requester after the pointer, wrapping modulo NUM_CH.
module usb_rr_arbiter
   import sie_defs_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [idx_w(NUM_CH)-1:0] ptr_i,
   output logic [idx_w(NUM_CH)-1:0] idx_o,
   output logic                     anyReq_o
);

   localparam int unsigned IDX_W = idx_w(NUM_CH);

   logic [IDX_W-1:0] cand;

   always_comb begin
      idx_o    = '0;
      cand     = '0;
      anyReq_o = |req_i;
      // Scan farthest to nearest so the nearest requester is the final write.
      for (int i = NUM_CH; i >= 1; i--) begin
         cand = IDX_W'((int'(ptr_i) + i) % int'(NUM_CH));
         if (req_i[cand]) idx_o = cand;
      end
   end

endmodule

// File: rtl/usb_sie_tx_arbiter.sv
// N-channel round-robin packet arbiter in front of the SIE transmit interface.
// Define USB_TX_ARB_STATS_EN to add per-channel completed-packet counters on pktCount_o.
module usb_sie_tx_arbiter
   import sie_defs_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter int unsigned DONE_TIMEOUT = 1023
`ifdef USB_TX_ARB_STATS_EN
   ,
   parameter int unsigned CNT_W        = 16
`endif
) (
   input  logic                     clk12_i,
   input  logic                     rstn_i,
   input  logic [NUM_CH-1:0]        chReqSendPacket_i,
   input  logic [NUM_CH-1:0]        chDataValid_i,
   input  logic [NUM_CH-1:0]        chIsLastByte_i,
   input  logic [8*NUM_CH-1:0]      chData_i,
   output logic [NUM_CH-1:0]        chAcceptNewData_o,
   output logic [NUM_CH-1:0]        chDone_o,
   output logic [NUM_CH-1:0]        chErr_o,
   output logic                     txReqSendPacket_o,
   output logic                     txDataValid_o,
   output logic                     txIsLastByte_o,
   output logic [7:0]               txData_o,
   input  logic                     txAcceptNewData_i,
   input  logic                     txDoneSending_i,
   output logic                     isSendingPhase_o,
   output logic [idx_w(NUM_CH)-1:0] grantIdx_o,
   output logic                     busy_o
`ifdef USB_TX_ARB_STATS_EN
   ,
   output logic [CNT_W*NUM_CH-1:0]  pktCount_o
`endif
);

   localparam int unsigned IDX_W = idx_w(NUM_CH);
   localparam int unsigned TO_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   tx_arb_state_t    state_q;
   logic [IDX_W-1:0] grant_q, ptr_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [NUM_CH-1:0] done_q, err_q;
   logic             tx_req_q, sending_q;

   logic [IDX_W-1:0] pick_idx;
   logic             any_req;
   logic             streaming, sel_valid, sel_last;
   logic [7:0]       sel_data;

   usb_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req_i    (chReqSendPacket_i),
      .ptr_i    (ptr_q),
      .idx_o    (pick_idx),
      .anyReq_o (any_req)
   );

   always_comb begin
      streaming         = (state_q == TX_ARB_STREAM);
      sel_valid         = chDataValid_i[grant_q];
      sel_last          = chIsLastByte_i[grant_q];
      sel_data          = chData_i[{grant_q, 3'b000} +: 8];
      chAcceptNewData_o = '0;
      if (streaming) chAcceptNewData_o[grant_q] = txAcceptNewData_i;
      txDataValid_o     = streaming & sel_valid;
      txIsLastByte_o    = streaming & sel_last;
      txData_o          = streaming ? sel_data : 8'h00;
   end

   always_ff @(posedge clk12_i) begin
      if (!rstn_i) begin
         state_q   <= TX_ARB_IDLE;
         grant_q   <= '0;
         ptr_q     <= IDX_W'(NUM_CH - 1);
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         done_q    <= '0;
         err_q     <= '0;
         tx_req_q  <= 1'b0;
         sending_q <= 1'b0;
      end else begin
         done_q <= '0;
         err_q  <= '0;
         unique case (state_q)
            TX_ARB_IDLE: begin
               if (any_req) begin
                  grant_q   <= pick_idx;
                  ptr_q     <= pick_idx;
                  tx_req_q  <= 1'b1;
                  sending_q <= 1'b1;
                  state_q   <= TX_ARB_REQ;
               end
            end
            TX_ARB_REQ: begin
               tx_req_q <= 1'b0;
               state_q  <= TX_ARB_STREAM;
            end
            TX_ARB_STREAM: begin
               if (sel_valid && txAcceptNewData_i && sel_last) begin
                  to_cnt_q <= '0;
                  state_q  <= TX_ARB_WAIT_DONE;
               end
            end
            TX_ARB_WAIT_DONE: begin
               // Done is checked first so it wins over a coincident timeout.
               if (txDoneSending_i || (to_cnt_q == TO_W'(DONE_TIMEOUT - 1))) begin
                  if (txDoneSending_i) done_q[grant_q] <= 1'b1;
                  else                 err_q[grant_q]  <= 1'b1;
                  sending_q <= 1'b0;
                  gap_cnt_q <= '0;
                  state_q   <= (GAP_CYCLES == 0) ? TX_ARB_IDLE : TX_ARB_GAP;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            TX_ARB_GAP: begin
               if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_q <= TX_ARB_IDLE;
               else                                     gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
            default: state_q <= TX_ARB_IDLE;
         endcase
      end
   end

   assign chDone_o          = done_q;
   assign chErr_o           = err_q;
   assign txReqSendPacket_o = tx_req_q;
   assign isSendingPhase_o  = sending_q;
   assign grantIdx_o        = grant_q;
   assign busy_o            = (state_q != TX_ARB_IDLE);

`ifdef USB_TX_ARB_STATS_EN
   logic [NUM_CH-1:0][CNT_W-1:0] pkt_cnt_q;

   always_ff @(posedge clk12_i) begin
      if (!rstn_i) begin
         pkt_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (done_q[k]) pkt_cnt_q[k] <= pkt_cnt_q[k] + CNT_W'(1);
         end
      end
   end

   assign pktCount_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_usb_sie_tx_arbiter.sv
// Bench for usb_sie_tx_arbiter: behavioural packet-level model checked every cycle plus
// directed scenarios with literal expectations. Stats checks only with USB_TX_ARB_STATS_EN.
module tb_usb_sie_tx_arbiter;

   localparam int unsigned NUM_CH       = 4;
   localparam int unsigned GAP_CYCLES   = 2;
   localparam int unsigned DONE_TIMEOUT = 1023;
   localparam int unsigned IDX_W        = 2;
`ifdef USB_TX_ARB_STATS_EN
   localparam int unsigned CNT_W        = 2;
`endif

   localparam int PH_IDLE   = 0;
   localparam int PH_REQ    = 1;
   localparam int PH_STREAM = 2;
   localparam int PH_WAIT   = 3;
   localparam int PH_GAP    = 4;

   logic clk12 = 1'b0;
   logic rstn;
   logic [NUM_CH-1:0]   ch_req, ch_valid, ch_last, ch_accept, ch_done, ch_err;
   logic [8*NUM_CH-1:0] ch_data;
   logic                tx_req, tx_valid, tx_last, tx_accept, tx_done_i, sending, busy;
   logic [7:0]          tx_data;
   logic [IDX_W-1:0]    grant;
`ifdef USB_TX_ARB_STATS_EN
   logic [CNT_W*NUM_CH-1:0] pkt_count;
`endif

   always #5 clk12 = ~clk12;

   usb_sie_tx_arbiter #(
      .NUM_CH       (NUM_CH),
      .GAP_CYCLES   (GAP_CYCLES),
      .DONE_TIMEOUT (DONE_TIMEOUT)
`ifdef USB_TX_ARB_STATS_EN
      ,
      .CNT_W        (CNT_W)
`endif
   ) dut (
      .clk12_i           (clk12),
      .rstn_i            (rstn),
      .chReqSendPacket_i (ch_req),
      .chDataValid_i     (ch_valid),
      .chIsLastByte_i    (ch_last),
      .chData_i          (ch_data),
      .chAcceptNewData_o (ch_accept),
      .chDone_o          (ch_done),
      .chErr_o           (ch_err),
      .txReqSendPacket_o (tx_req),
      .txDataValid_o     (tx_valid),
      .txIsLastByte_o    (tx_last),
      .txData_o          (tx_data),
      .txAcceptNewData_i (tx_accept),
      .txDoneSending_i   (tx_done_i),
      .isSendingPhase_o  (sending),
      .grantIdx_o        (grant),
      .busy_o            (busy)
`ifdef USB_TX_ARB_STATS_EN
      ,
      .pktCount_o        (pkt_count)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Channel sources and SIE responder.
   logic [7:0]  pkt [NUM_CH][4];
   int unsigned plen [NUM_CH];
   int unsigned sidx [NUM_CH];
   int unsigned pkts_left [NUM_CH];
   int          acc_mode;
   bit          done_en;
   int          done_cnt;
   int          cyc;

   // Packet-level model of the arbiter.
   int          m_phase;
   int unsigned m_grant, m_ptr, m_wait, m_gap;
   logic [NUM_CH-1:0] m_done, m_err;

   // Observations for the directed scenarios.
   int unsigned grants [$];
   logic [7:0]  bytes_q [$];
   int unsigned gaps [$];
   int          ndone [NUM_CH];
   int          nerr [NUM_CH];
   int          first_req_cyc, last_hs_cyc, err_cyc, low_run;
   bit          seen_send;

   task automatic apply_src();
      for (int k = 0; k < NUM_CH; k++) begin
         ch_req[k]        = (pkts_left[k] > 0);
         ch_valid[k]      = ch_req[k] && (sidx[k] < plen[k]);
         ch_last[k]       = ch_valid[k] && (sidx[k] == plen[k] - 1);
         ch_data[8*k +: 8] = ch_valid[k] ? pkt[k][sidx[k]] : 8'h00;
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_grant = 0;
      m_ptr   = NUM_CH - 1;
      m_wait  = 0;
      m_gap   = 0;
      m_done  = '0;
      m_err   = '0;
   endtask

   task automatic leave_wait();
      if (GAP_CYCLES == 0) m_phase = PH_IDLE;
      else begin
         m_phase = PH_GAP;
         m_gap   = GAP_CYCLES;
      end
   endtask

   task automatic compare_model();
      bit          strm;
      logic [NUM_CH-1:0] e_acc;
      strm  = (m_phase == PH_STREAM);
      e_acc = '0;
      if (strm) e_acc[m_grant] = tx_accept;
      chk("txReqSendPacket", tx_req, m_phase == PH_REQ);
      chk("isSendingPhase", sending, m_phase inside {PH_REQ, PH_STREAM, PH_WAIT});
      chk("busy", busy, m_phase != PH_IDLE);
      chk("grantIdx", grant, m_grant);
      chk("txDataValid", tx_valid, strm && ch_valid[m_grant]);
      chk("chAcceptNewData", ch_accept, e_acc);
      chk("chDone", ch_done, m_done);
      chk("chErr", ch_err, m_err);
      if (strm) begin
         chk("txIsLastByte", tx_last, ch_last[m_grant]);
         chk("txData", tx_data, ch_data[8*m_grant +: 8]);
      end
   endtask

   task automatic step_model();
      bit found;
      if (!rstn) begin
         model_reset();
         return;
      end
      m_done = '0;
      m_err  = '0;
      case (m_phase)
         PH_IDLE: begin
            found = 0;
            for (int o = 1; o <= NUM_CH; o++) begin
               if (!found && ch_req[(m_ptr + o) % NUM_CH]) begin
                  found   = 1;
                  m_grant = (m_ptr + o) % NUM_CH;
               end
            end
            if (found) begin
               m_ptr   = m_grant;
               m_phase = PH_REQ;
            end
         end
         PH_REQ: m_phase = PH_STREAM;
         PH_STREAM: begin
            if (ch_valid[m_grant] && tx_accept && ch_last[m_grant]) begin
               m_phase = PH_WAIT;
               m_wait  = 0;
            end
         end
         PH_WAIT: begin
            if (tx_done_i) begin
               m_done[m_grant] = 1'b1;
               leave_wait();
            end else begin
               m_wait++;
               if (m_wait == DONE_TIMEOUT) begin
                  m_err[m_grant] = 1'b1;
                  leave_wait();
               end
            end
         end
         PH_GAP: begin
            m_gap--;
            if (m_gap == 0) m_phase = PH_IDLE;
         end
         default: m_phase = PH_IDLE;
      endcase
   endtask

   task automatic observe();
      if (tx_req) begin
         grants.push_back(grant);
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (tx_valid && tx_accept) begin
         bytes_q.push_back(tx_data);
         if (tx_last) last_hs_cyc = cyc;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_done[k]) ndone[k]++;
         if (ch_err[k]) begin
            nerr[k]++;
            err_cyc = cyc;
         end
      end
      if (sending) begin
         if (seen_send && low_run > 0) gaps.push_back(low_run);
         low_run   = 0;
         seen_send = 1;
      end else if (seen_send) begin
         low_run++;
      end
   endtask

   task automatic clear_obs();
      grants.delete();
      bytes_q.delete();
      gaps.delete();
      for (int k = 0; k < NUM_CH; k++) begin
         ndone[k] = 0;
         nerr[k]  = 0;
      end
      first_req_cyc = -1;
      last_hs_cyc   = -1;
      err_cyc       = -1;
      low_run       = 0;
      seen_send     = 0;
   endtask

   // One clock: check and observe at negedge, advance model, then drive after the posedge.
   task automatic cycle();
      logic [NUM_CH-1:0] hs, dn;
      bit last_hs;
      @(negedge clk12);
      compare_model();
      observe();
      hs      = ch_accept & ch_valid;
      dn      = ch_done | ch_err;
      last_hs = tx_valid && tx_accept && tx_last;
      step_model();
      @(posedge clk12);
      #1;
      cyc++;
      for (int k = 0; k < NUM_CH; k++) begin
         if (hs[k]) sidx[k]++;
         if (dn[k]) begin
            if (pkts_left[k] > 0) pkts_left[k]--;
            sidx[k] = 0;
         end
      end
      if (last_hs && done_en) done_cnt = 2;
      tx_done_i = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) tx_done_i = 1'b1;
      end
      tx_accept = (acc_mode == 0) ? 1'b1 : (acc_mode == 1) ? ((cyc % 2) == 1) : 1'b0;
      apply_src();
   endtask

   task automatic do_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         pkts_left[k] = 0;
         sidx[k]      = 0;
      end
      done_cnt  = 0;
      tx_done_i = 1'b0;
      acc_mode  = 0;
      tx_accept = 1'b1;
      done_en   = 1;
      apply_src();
      rstn = 1'b0;
      cycle();
      cycle();
      rstn = 1'b1;
      clear_obs();
   endtask

   task automatic run_until_idle(input string name, input int max_cycles);
      int  n;
      bit  pending;
      n = 0;
      do begin
         cycle();
         n++;
         pending = busy;
         for (int k = 0; k < NUM_CH; k++) if (pkts_left[k] > 0) pending = 1;
      end while (pending && n < max_cycles);
      chk(name, n < max_cycles, 1);
   endtask

   task automatic set_pkt(input int k, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int unsigned len);
      pkt[k][0] = b0;
      pkt[k][1] = b1;
      pkt[k][2] = b2;
      pkt[k][3] = b3;
      plen[k]   = len;
   endtask

   initial begin
      int n;
      logic [7:0] t1_exp [3];
      cyc  = 0;
      rstn = 1'b0;
      for (int k = 0; k < NUM_CH; k++) set_pkt(k, 8'hC3, 8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30, 2);
      model_reset();
      clear_obs();
      do_reset();

      // 1: single packet on ch0, spurious done in IDLE ignored.
      chk("t1 reset busy", busy, 0);
      chk("t1 reset sending", sending, 0);
      chk("t1 reset grant", grant, 0);
      tx_done_i = 1'b1;
      cycle();
      set_pkt(0, 8'hC3, 8'h11, 8'h22, 8'h00, 3);
      pkts_left[0] = 1;
      apply_src();
      n = cyc;
      run_until_idle("t1 finish", 200);
      chk("t1 req latency", first_req_cyc - n, 1);
      chk("t1 nbytes", bytes_q.size(), 3);
      t1_exp = '{8'hC3, 8'h11, 8'h22};
      if (bytes_q.size() == 3) for (int i = 0; i < 3; i++) chk("t1 byte", bytes_q[i], t1_exp[i]);
      chk("t1 done ch0", ndone[0], 1);
      chk("t1 no err", nerr[0], 0);

      // 2: ch1..3 together from reset.
      do_reset();
      for (int k = 1; k < 4; k++) pkts_left[k] = 1;
      apply_src();
      run_until_idle("t2 finish", 300);
      chk("t2 ngrants", grants.size(), 3);
      if (grants.size() == 3) begin
         chk("t2 grant0", grants[0], 1);
         chk("t2 grant1", grants[1], 2);
         chk("t2 grant2", grants[2], 3);
      end
      chk("t2 ngaps", gaps.size(), 2);
      foreach (gaps[i]) chk("t2 gap length", gaps[i], GAP_CYCLES + 1);

      // 3: ch0 holds request across packets, ch2 competes; accept toggles.
      do_reset();
      acc_mode     = 1;
      pkts_left[0] = 2;
      pkts_left[2] = 2;
      apply_src();
      run_until_idle("t3 finish", 400);
      chk("t3 ngrants", grants.size(), 4);
      if (grants.size() == 4) begin
         chk("t3 grant0", grants[0], 0);
         chk("t3 grant1", grants[1], 2);
         chk("t3 grant2", grants[2], 0);
         chk("t3 grant3", grants[3], 2);
      end
      chk("t3 done ch0", ndone[0], 2);
      chk("t3 done ch2", ndone[2], 2);

      // 4: SIE never signals done.
      do_reset();
      done_en      = 0;
      pkts_left[1] = 1;
      apply_src();
      run_until_idle("t4 finish", DONE_TIMEOUT + 100);
      chk("t4 err ch1", nerr[1], 1);
      chk("t4 no done", ndone[1], 0);
      chk("t4 err timing", err_cyc - last_hs_cyc, DONE_TIMEOUT + 1);
      chk("t4 idle after", busy, 0);

      // 5: reset while streaming a stalled packet, then resend.
      do_reset();
      acc_mode = 2;
      tx_accept = 1'b0;
      set_pkt(0, 8'hC3, 8'hA1, 8'hA2, 8'hA3, 4);
      pkts_left[0] = 1;
      apply_src();
      n = 0;
      while (!tx_valid && n < 10) begin
         cycle();
         n++;
      end
      chk("t5 reached stream", tx_valid, 1);
      rstn = 1'b0;
      cycle();
      chk("t5 rst sending", sending, 0);
      chk("t5 rst busy", busy, 0);
      chk("t5 rst txreq", tx_req, 0);
      chk("t5 rst txvalid", tx_valid, 0);
      chk("t5 rst accept", ch_accept, 0);
      chk("t5 rst done/err", {ch_done, ch_err}, 0);
      rstn     = 1'b1;
      sidx[0]  = 0;
      acc_mode = 0;
      tx_accept = 1'b1;
      apply_src();
      clear_obs();
      run_until_idle("t5 finish", 200);
      chk("t5 regrant", grants.size() == 1 && grants[0] == 0, 1);
      chk("t5 nbytes", bytes_q.size(), 4);
      chk("t5 done ch0", ndone[0], 1);

`ifdef USB_TX_ARB_STATS_EN
      // 6: five packets on ch1 wrap its 2-bit counter to 1.
      do_reset();
      pkts_left[1] = 5;
      apply_src();
      run_until_idle("t6 finish", 600);
      for (int k = 0; k < NUM_CH; k++) begin
         chk("t6 pktCount", pkt_count[CNT_W*k +: CNT_W], (k == 1) ? 1 : 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
